// File: rtl/keypad_matrix_emulator.sv
// Behavioural 4x4 keypad responder: queued key commands, row lines driven low when the active column is strobed.
// Define KEYPAD_BOUNCE_EN to add contact-bounce windows around each press and release.
module keypad_matrix_emulator #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned HOLD_W        = 16,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned BOUNCE_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    cmd_key,
  input  logic [HOLD_W-1:0]             cmd_hold,
  input  logic [3:0]                    shift_col,
  output logic [3:0]                    row,
  output logic                          busy,
  output logic                          pressed,
  output logic [3:0]                    key_active,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
`ifdef KEYPAD_BOUNCE_EN
  localparam int unsigned BW = $clog2(BOUNCE_CYCLES) + 2;
  localparam logic [BW-1:0] BNC_LAST = BW'(BOUNCE_CYCLES - 1);
`endif

  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_e;

  logic [3:0]        key_mem_q  [FIFO_DEPTH];
  logic [HOLD_W-1:0] hold_mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push, pop;

  state_e            state_q, state_d;
  logic [3:0]        act_key_q, act_key_d;
  logic [HOLD_W-1:0] act_hold_q, act_hold_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_last;
  logic [GW-1:0]     gap_q, gap_d;
  logic              contact_q, contact_d;
  logic [3:0]        row_q, row_d;
`ifdef KEYPAD_BOUNCE_EN
  logic [BW-1:0]     bnc_q, bnc_d;
`endif

  assign cmd_ready = (count_q < DEPTH_C);
  assign push      = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      key_mem_q[wr_ptr_q]  <= cmd_key;
      hold_mem_q[wr_ptr_q] <= cmd_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A zero hold request still closes the contact for one cycle.
  assign hold_last = (act_hold_q == '0) ? '0 : act_hold_q - HOLD_W'(1);

  always_comb begin
    state_d    = state_q;
    act_key_d  = act_key_q;
    act_hold_d = act_hold_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    contact_d  = contact_q;
    pop        = 1'b0;
`ifdef KEYPAD_BOUNCE_EN
    bnc_d      = bnc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          act_key_d  = key_mem_q[rd_ptr_q];
          act_hold_d = hold_mem_q[rd_ptr_q];
          cnt_d      = '0;
          contact_d  = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
          bnc_d      = '0;
          state_d    = BOUNCE_IN;
`else
          state_d    = HOLD;
`endif
        end
      end
`ifdef KEYPAD_BOUNCE_EN
      BOUNCE_IN: begin
        if (bnc_q == BNC_LAST) begin
          state_d   = HOLD;
          contact_d = 1'b1;
          cnt_d     = '0;
        end else begin
          bnc_d     = bnc_q + BW'(1);
          contact_d = ~bnc_d[1];
        end
      end
      BOUNCE_OUT: begin
        if (bnc_q == BNC_LAST) begin
          state_d   = GAP;
          contact_d = 1'b0;
          gap_d     = '0;
        end else begin
          bnc_d     = bnc_q + BW'(1);
          contact_d = ~bnc_d[1];
        end
      end
`endif
      HOLD: begin
        if (cnt_q == hold_last) begin
`ifdef KEYPAD_BOUNCE_EN
          state_d   = BOUNCE_OUT;
          contact_d = 1'b1;
          bnc_d     = '0;
`else
          state_d   = GAP;
          contact_d = 1'b0;
          gap_d     = '0;
`endif
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d   = IDLE;
          act_key_d = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_d = 4'hF;
    for (int unsigned r = 0; r < 4; r++) begin
      if (contact_q && (act_key_q[3:2] == 2'(r)) && !shift_col[act_key_q[1:0]]) begin
        row_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      act_key_q  <= '0;
      act_hold_q <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      contact_q  <= 1'b0;
      row_q      <= 4'hF;
`ifdef KEYPAD_BOUNCE_EN
      bnc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      act_key_q  <= act_key_d;
      act_hold_q <= act_hold_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      contact_q  <= contact_d;
      row_q      <= row_d;
`ifdef KEYPAD_BOUNCE_EN
      bnc_q      <= bnc_d;
`endif
    end
  end

  assign row        = row_q;
  assign pressed    = contact_q;
  assign key_active = act_key_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator; expectations are hand-derived cycle counts.
module tb_keypad_matrix_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_key;
  logic [15:0] cmd_hold;
  logic [3:0]  shift_col;
  logic [3:0]  row;
  logic        busy;
  logic        pressed;
  logic [3:0]  key_active;
  logic [2:0]  fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_matrix_emulator #(
    .FIFO_DEPTH(4),
    .HOLD_W(16),
    .GAP_CYCLES(16),
    .BOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_key(cmd_key),
    .cmd_hold(cmd_hold),
    .shift_col(shift_col),
    .row(row),
    .busy(busy),
    .pressed(pressed),
    .key_active(key_active),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Records each low run on row: key_active, row value, start edge, length, preceding idle run.
  logic       mon_en = 1'b0;
  logic [3:0] q_key[$];
  logic [3:0] q_row[$];
  int         q_start[$];
  int         q_len[$];
  int         q_gap[$];
  logic       in_low = 1'b0;
  int         run_len = 0;
  int         f_run = 0;

  always @(negedge clk) begin
    if (!mon_en) begin
      q_key.delete(); q_row.delete(); q_start.delete(); q_len.delete(); q_gap.delete();
      in_low = 1'b0; run_len = 0; f_run = 0;
    end else if (row != 4'hF) begin
      if (!in_low) begin
        in_low = 1'b1;
        q_key.push_back(key_active);
        q_row.push_back(row);
        q_start.push_back(cyc);
        q_gap.push_back(f_run);
        run_len = 0;
      end
      run_len++;
    end else begin
      if (in_low) begin
        q_len.push_back(run_len);
        in_low = 1'b0;
        f_run = 0;
      end
      f_run++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    mon_en = 1'b0;
    @(negedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_key = '0;
    cmd_hold = '0;
    shift_col = 4'hF;
    repeat (3) tick();
    check_eq("rst_row", row, 4'hF);
    check_eq("rst_pressed", pressed, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_key_active", key_active, 4'h0);
    check_eq("rst_fifo_count", fifo_count, 3'd0);
    check_eq("rst_cmd_ready", cmd_ready, 1'b1);
    reset = 1'b0;
  endtask

  task automatic push_one(input logic [3:0] k, input logic [15:0] h);
    cmd_valid = 1'b1;
    cmd_key = k;
    cmd_hold = h;
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [3:0] keys2 [6] = '{4'h1, 4'h6, 4'hB, 4'hC, 4'h7, 4'h9};
  logic [3:0] exp_row;
  logic [3:0] sc;
  int p;
  int n;
  int waited;
  logic exp_p;
  int jj;

  initial begin
    do_reset();

`ifndef KEYPAD_BOUNCE_EN
    // Test 1: key row1/col2, hold 10, matching column strobe.
    shift_col = 4'b1011;
    mon_clear();
    push_one(4'b0110, 16'd10);
    p = cyc;
    tick();
    check_eq("t1_key_active", key_active, 4'h6);
    check_eq("t1_pressed", pressed, 1'b1);
    check_eq("t1_busy", busy, 1'b1);
    check_eq("t1_fifo_popped", fifo_count, 3'd0);
    repeat (39) tick();
    check_eq("t1_runs", q_key.size(), 1);
    if (q_len.size() == 1) begin
      check_eq("t1_row", q_row[0], 4'b1101);
      check_eq("t1_len", q_len[0], 10);
      check_eq("t1_start", q_start[0], p + 2);
    end
    check_eq("t1_idle", busy, 1'b0);

    // Test 1b: non-matching column never pulls a row low.
    shift_col = 4'b1110;
    mon_clear();
    push_one(4'b0110, 16'd10);
    tick();
    check_eq("t1b_pressed", pressed, 1'b1);
    repeat (39) tick();
    check_eq("t1b_runs", q_key.size(), 0);

    // Test 2: fill the queue behind an executing command; order and gaps.
    shift_col = 4'h0;
    mon_clear();
    cmd_hold = 16'd3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_key = keys2[i];
      tick();
    end
    check_eq("t2_full_count", fifo_count, 3'd4);
    check_eq("t2_full_ready", cmd_ready, 1'b0);
    cmd_key = keys2[5];
    waited = 0;
    n = 0;
    while (n < 100) begin
      if (cmd_ready) begin
        tick();
        n = 1000;
      end else begin
        tick();
        waited++;
        n++;
      end
    end
    cmd_valid = 1'b0;
    check_eq("t2_sixth_wait", waited, 17);
    n = 0;
    while (busy && n < 600) begin
      tick();
      n++;
    end
    check_eq("t2_drained", busy, 1'b0);
    repeat (2) tick();
    check_eq("t2_runs", q_key.size(), 6);
    if (q_len.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        exp_row = 4'b0001 << keys2[i][3:2];
        exp_row = ~exp_row;
        check_eq("t2_order_key", q_key[i], keys2[i]);
        check_eq("t2_row", q_row[i], exp_row);
        check_eq("t2_len", q_len[i], 3);
        if (i > 0) check_eq("t2_gap", q_gap[i], 17);
      end
    end

    // Test 3: zero hold behaves as one cycle; busy drops after the gap.
    shift_col = 4'b1110;
    mon_clear();
    push_one(4'b0000, 16'd0);
    p = cyc;
    repeat (17) tick();
    check_eq("t3_busy_in_gap", busy, 1'b1);
    tick();
    check_eq("t3_busy_done", busy, 1'b0);
    repeat (2) tick();
    check_eq("t3_runs", q_key.size(), 1);
    if (q_len.size() == 1) begin
      check_eq("t3_row", q_row[0], 4'b1110);
      check_eq("t3_len", q_len[0], 1);
      check_eq("t3_start", q_start[0], p + 2);
    end

    // Test 4: reset in the middle of a hold flushes the queue.
    shift_col = 4'b0111;
    mon_en = 1'b0;
    push_one(4'hF, 16'd50);
    push_one(4'h5, 16'd5);
    repeat (3) tick();
    check_eq("t4_row_held", row, 4'b0111);
    check_eq("t4_count_before", fifo_count, 3'd1);
    reset = 1'b1;
    tick();
    check_eq("t4_row_reset", row, 4'hF);
    check_eq("t4_count_reset", fifo_count, 3'd0);
    check_eq("t4_busy_reset", busy, 1'b0);
    check_eq("t4_pressed_reset", pressed, 1'b0);
    check_eq("t4_key_reset", key_active, 4'h0);
    reset = 1'b0;
    shift_col = 4'h0;
    mon_clear();
    repeat (80) tick();
    check_eq("t4_no_exec", q_key.size(), 0);
    check_eq("t4_busy_after", busy, 1'b0);

    // Test 5: alternating column strobes show the one-cycle row latency.
    mon_en = 1'b0;
    shift_col = 4'b1110;
    push_one(4'b1001, 16'd12);
    for (int k = 1; k <= 20; k++) begin
      sc = (k % 2 == 1) ? 4'b1101 : 4'b1110;
      shift_col = sc;
      tick();
      exp_row = (k >= 2 && k <= 13 && sc == 4'b1101) ? 4'b1011 : 4'hF;
      check_eq("t5_row", row, exp_row);
    end
    shift_col = 4'hF;
    repeat (20) tick();
    check_eq("t5_idle", busy, 1'b0);
`else
    // Test 6: bounce at press and release around a 20-cycle hold.
    shift_col = 4'b1011;
    push_one(4'b0110, 16'd20);
    for (int k = 1; k <= 56; k++) begin
      tick();
      jj = k - 2;
      if (jj < 0)       exp_p = 1'b0;
      else if (jj < 8)  exp_p = ((jj % 4) < 2);
      else if (jj < 28) exp_p = 1'b1;
      else if (jj < 36) exp_p = (((jj - 28) % 4) < 2);
      else              exp_p = 1'b0;
      exp_row = exp_p ? 4'b1101 : 4'hF;
      check_eq("t6_row", row, exp_row);
    end
    check_eq("t6_idle", busy, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
